// File: rtl/scara_joint_stepper.sv
// Multi-axis step/dir generator: drives every joint toward a latched signed target
// at a shared step rate and reports completion or abort with one-cycle pulses.
module scara_joint_stepper #(
  parameter int NUM_AXES = 2,
  parameter int POS_W    = 14,
  parameter int DIV_W    = 16,
  parameter int PULSE_W  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_AXES*POS_W-1:0] target_pos,
  input  logic [DIV_W-1:0]          step_period,
  input  logic                      target_valid,
  output logic                      target_ready,
  input  logic                      abort,
  output logic [NUM_AXES-1:0]       step,
  output logic [NUM_AXES-1:0]       dir,
  output logic [NUM_AXES*POS_W-1:0] cur_pos,
  output logic                      busy,
  output logic                      done,
  output logic                      aborted
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MOVE  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_ABORT = 2'd3;

  localparam int              PCW        = (PULSE_W < 2) ? 1 : $clog2(PULSE_W);
  localparam logic [DIV_W-1:0] MIN_PERIOD = DIV_W'(2 * PULSE_W);

  logic [1:0]                r_state;
  logic [NUM_AXES*POS_W-1:0] r_tgt;
  logic [NUM_AXES*POS_W-1:0] r_pos;
  logic [DIV_W-1:0]          r_period;
  logic [DIV_W-1:0]          r_cnt;
  logic [PCW-1:0]            r_pulseCnt;
  logic [NUM_AXES-1:0]       r_step;
  logic [NUM_AXES-1:0]       r_dir;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_aborted;

  logic [NUM_AXES-1:0]       w_atTarget;
  logic [NUM_AXES-1:0]       w_newDir;
  logic [NUM_AXES*POS_W-1:0] w_stepPos;
  logic [DIV_W-1:0]          w_effPeriod;
  logic                      w_allAt;
  logic                      w_tick;

  // Period is widened so a pulse always has at least PULSE_W low cycles after it.
  assign w_effPeriod = (step_period < MIN_PERIOD) ? MIN_PERIOD : step_period;
  assign w_allAt     = &w_atTarget;
  assign w_tick      = (r_cnt == (r_period - DIV_W'(1)));

  always_comb begin
    w_atTarget = '0;
    w_newDir   = '0;
    w_stepPos  = '0;
    for (int i = 0; i < NUM_AXES; i++) begin
      w_atTarget[i] = (r_pos[i*POS_W +: POS_W] == r_tgt[i*POS_W +: POS_W]);
      w_newDir[i]   = ($signed(target_pos[i*POS_W +: POS_W]) > $signed(r_pos[i*POS_W +: POS_W]));
      w_stepPos[i*POS_W +: POS_W] = r_dir[i] ? (r_pos[i*POS_W +: POS_W] + POS_W'(1))
                                             : (r_pos[i*POS_W +: POS_W] - POS_W'(1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_tgt      <= '0;
      r_pos      <= '0;
      r_period   <= MIN_PERIOD;
      r_cnt      <= '0;
      r_pulseCnt <= '0;
      r_step     <= '0;
      r_dir      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      if (r_step != '0) begin
        if (r_pulseCnt == '0) r_step <= '0;
        else                  r_pulseCnt <= r_pulseCnt - PCW'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (target_valid) begin
            r_tgt    <= target_pos;
            r_period <= w_effPeriod;
            r_dir    <= w_newDir;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_MOVE;
          end
        end
        S_MOVE: begin
          // Abort wins over both completion and a pending tick, and cuts any live pulse.
          if (abort) begin
            r_step    <= '0;
            r_busy    <= 1'b0;
            r_aborted <= 1'b1;
            r_state   <= S_ABORT;
          end else if (w_allAt && (r_step == '0)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= w_tick ? '0 : (r_cnt + DIV_W'(1));
            if (w_tick && !w_allAt) begin
              r_step     <= ~w_atTarget;
              r_pulseCnt <= PCW'(PULSE_W - 1);
              for (int i = 0; i < NUM_AXES; i++) begin
                if (!w_atTarget[i]) r_pos[i*POS_W +: POS_W] <= w_stepPos[i*POS_W +: POS_W];
              end
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign target_ready = (r_state == S_IDLE);
  assign step         = r_step;
  assign dir          = r_dir;
  assign cur_pos      = r_pos;
  assign busy         = r_busy;
  assign done         = r_done;
  assign aborted      = r_aborted;

endmodule

// File: tb/tb_scara_joint_stepper.sv
// Directed bench for scara_joint_stepper (2 axes, 14-bit positions, PULSE_W=4).
// Each task drives one scenario and checks the outputs against hand-derived values.
module tb_scara_joint_stepper;

  logic        clk = 1'b0;
  logic        reset;
  logic [27:0] targetPos;
  logic [15:0] stepPeriod;
  logic        targetValid;
  logic        targetReady;
  logic        abortIn;
  logic [1:0]  step;
  logic [1:0]  dir;
  logic [27:0] curPos;
  logic        busy;
  logic        done;
  logic        aborted;

  int checks = 0;
  int errors = 0;

  scara_joint_stepper #(
    .NUM_AXES(2), .POS_W(14), .DIV_W(16), .PULSE_W(4)
  ) dut (
    .clk(clk), .reset(reset), .target_pos(targetPos), .step_period(stepPeriod),
    .target_valid(targetValid), .target_ready(targetReady), .abort(abortIn),
    .step(step), .dir(dir), .cur_pos(curPos), .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the accepting edge (sample point k=0).
  task automatic issueMove(input logic [13:0] t0, input logic [13:0] t1, input logic [15:0] per);
    targetPos   = {t1, t0};
    stepPeriod  = per;
    targetValid = 1'b1;
    stepCycle();
    targetValid = 1'b0;
  endtask

  task automatic waitDone(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      stepCycle();
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    targetValid = 1'b0;
    abortIn = 1'b0;
    targetPos = '0;
    stepPeriod = 16'd10;
    #13;
    checks++;
    if ({step, dir, curPos, busy, done, aborted} !== 33'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", {step, dir, curPos, busy, done, aborted});
    end
    checks++;
    if (targetReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready: got %b expected 1", targetReady);
    end
    @(negedge clk);
    reset = 1'b0;
    stepCycle();
    checks++;
    if (targetReady !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release: ready %b busy %b expected 1 0", targetReady, busy);
    end
  endtask

  task automatic test_basic_move();
    logic [1:0] expStep;
    issueMove(14'd3, 14'h3FFF, 16'd10);
    checks++;
    if (dir !== 2'b01) begin
      errors++;
      $display("[TB] FAIL basic_dir: got %b expected 01", dir);
    end
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) stepCycle();
      expStep[0] = (k >= 10 && k <= 13) || (k >= 20 && k <= 23) || (k >= 30 && k <= 33);
      expStep[1] = (k >= 10 && k <= 13);
      checks++;
      if (step !== expStep) begin
        errors++;
        $display("[TB] FAIL basic_step k=%0d: got %b expected %b", k, step, expStep);
      end
      checks++;
      if (done !== (k == 35)) begin
        errors++;
        $display("[TB] FAIL basic_done k=%0d: got %b expected %b", k, done, (k == 35));
      end
      checks++;
      if (busy !== (k < 35)) begin
        errors++;
        $display("[TB] FAIL basic_busy k=%0d: got %b expected %b", k, busy, (k < 35));
      end
    end
    checks++;
    if (curPos !== {14'h3FFF, 14'd3}) begin
      errors++;
      $display("[TB] FAIL basic_pos: got %h expected %h", curPos, {14'h3FFF, 14'd3});
    end
    checks++;
    if (dir !== 2'b01 || targetReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_idle: dir %b ready %b expected 01 1", dir, targetReady);
    end
  endtask

  task automatic test_zero_move();
    bit seen;
    issueMove(14'd5, 14'd5, 16'd8);
    waitDone(200, seen);
    checks++;
    if (!seen || curPos !== {14'd5, 14'd5}) begin
      errors++;
      $display("[TB] FAIL zero_setup: seen %b pos %h expected 1 %h", seen, curPos, {14'd5, 14'd5});
    end
    stepCycle();
    issueMove(14'd5, 14'd5, 16'd8);
    checks++;
    if (busy !== 1'b1 || step !== 2'b00 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_k0: busy %b step %b done %b expected 1 00 0", busy, step, done);
    end
    stepCycle();
    checks++;
    if (done !== 1'b1 || step !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_done: done %b step %b busy %b expected 1 00 0", done, step, busy);
    end
    stepCycle();
    checks++;
    if (done !== 1'b0 || targetReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL zero_after: done %b ready %b expected 0 1", done, targetReady);
    end
  endtask

  task automatic test_min_period();
    logic [1:0] expStep;
    issueMove(14'd6, 14'd5, 16'd1);
    for (int k = 0; k <= 14; k++) begin
      if (k > 0) stepCycle();
      expStep = {1'b0, (k >= 8 && k <= 11)};
      checks++;
      if (step !== expStep) begin
        errors++;
        $display("[TB] FAIL minper_step k=%0d: got %b expected %b", k, step, expStep);
      end
      checks++;
      if (done !== (k == 13)) begin
        errors++;
        $display("[TB] FAIL minper_done k=%0d: got %b expected %b", k, done, (k == 13));
      end
    end
    checks++;
    if (curPos !== {14'd5, 14'd6}) begin
      errors++;
      $display("[TB] FAIL minper_pos: got %h expected %h", curPos, {14'd5, 14'd6});
    end
  endtask

  task automatic test_abort();
    issueMove(14'd20, 14'd0, 16'd10);
    for (int k = 1; k <= 11; k++) stepCycle();
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (step !== 2'b00 || curPos !== 28'd0 || busy !== 1'b0 || targetReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset: step %b pos %h busy %b ready %b expected 00 0 0 1",
               step, curPos, busy, targetReady);
    end
    @(negedge clk);
    reset = 1'b0;
    stepCycle();
    issueMove(14'd100, 14'd0, 16'd10);
    for (int k = 1; k <= 40; k++) begin
      stepCycle();
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL abort_nodone k=%0d: got %b expected 0", k, done);
      end
      if (k == 30) begin
        checks++;
        if (step !== 2'b01 || curPos !== {14'd0, 14'd3}) begin
          errors++;
          $display("[TB] FAIL abort_pre: step %b pos %h expected 01 %h", step, curPos, {14'd0, 14'd3});
        end
        abortIn = 1'b1;
      end
      if (k == 31) begin
        abortIn = 1'b0;
        checks++;
        if (step !== 2'b00 || aborted !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("[TB] FAIL abort_hit: step %b aborted %b busy %b expected 00 1 0", step, aborted, busy);
        end
      end
      if (k == 32) begin
        checks++;
        if (aborted !== 1'b0 || targetReady !== 1'b1) begin
          errors++;
          $display("[TB] FAIL abort_after: aborted %b ready %b expected 0 1", aborted, targetReady);
        end
      end
    end
    checks++;
    if (curPos !== {14'd0, 14'd3} || step !== 2'b00) begin
      errors++;
      $display("[TB] FAIL abort_hold: pos %h step %b expected %h 00", curPos, step, {14'd0, 14'd3});
    end
    abortIn = 1'b1;
    stepCycle();
    abortIn = 1'b0;
    checks++;
    if (aborted !== 1'b0 || targetReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_idle: aborted %b ready %b expected 0 1", aborted, targetReady);
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    issueMove(14'd10, 14'd0, 16'd8);
    for (int k = 1; k <= 5; k++) begin
      stepCycle();
      if (k == 3) begin
        targetPos   = {14'd50, 14'd50};
        targetValid = 1'b1;
      end
      if (k == 4) begin
        checks++;
        if (targetReady !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("[TB] FAIL b2b_busy: ready %b busy %b expected 0 1", targetReady, busy);
        end
      end
      if (k == 5) targetValid = 1'b0;
    end
    waitDone(200, seen);
    checks++;
    if (!seen || curPos !== {14'd0, 14'd10}) begin
      errors++;
      $display("[TB] FAIL b2b_first: seen %b pos %h expected 1 %h", seen, curPos, {14'd0, 14'd10});
    end
    stepCycle();
    issueMove(14'h2000, 14'd2, 16'd1);
    checks++;
    if (dir !== 2'b10) begin
      errors++;
      $display("[TB] FAIL b2b_dir: got %b expected 10", dir);
    end
    waitDone(70000, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL b2b_timeout: done seen %b expected 1", seen);
    end
    checks++;
    if (curPos !== {14'd2, 14'h2000}) begin
      errors++;
      $display("[TB] FAIL b2b_neg: got %h expected %h", curPos, {14'd2, 14'h2000});
    end
    for (int k = 0; k < 20; k++) stepCycle();
    checks++;
    if (curPos !== {14'd2, 14'h2000} || targetReady !== 1'b1 || step !== 2'b00) begin
      errors++;
      $display("[TB] FAIL b2b_hold: pos %h ready %b step %b", curPos, targetReady, step);
    end
  endtask

  initial begin
    test_reset();
    test_basic_move();
    test_zero_move();
    test_min_period();
    test_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
